// File: rtl/rom_arbiter.sv
// rom_arbiter: two-port round-robin arbiter in front of a combinational ROM with one-entry response slots.
// Define ROM_ARB_FIXED_PRI_EN to replace round-robin with fixed port-0 priority.
module rom_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ROM_BLOCK  = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req0_valid,
  input  logic [ADDR_WIDTH-1:0] i_req0_addr,
  output logic                  o_req0_ready,
  input  logic                  i_req1_valid,
  input  logic [ADDR_WIDTH-1:0] i_req1_addr,
  output logic                  o_req1_ready,
  output logic                  o_rsp0_valid,
  output logic [DATA_WIDTH-1:0] o_rsp0_data,
  output logic                  o_rsp0_err,
  input  logic                  i_rsp0_ready,
  output logic                  o_rsp1_valid,
  output logic [DATA_WIDTH-1:0] o_rsp1_data,
  output logic                  o_rsp1_err,
  input  logic                  i_rsp1_ready,
  output logic [ADDR_WIDTH-1:0] o_rom_addr,
  input  logic [DATA_WIDTH-1:0] i_rom_data
);
  localparam logic [ADDR_WIDTH:0] rom_limit = (ADDR_WIDTH+1)'(ROM_BLOCK);
  logic elig0, elig1, gnt0, gnt1, oor;
  logic [DATA_WIDTH-1:0] cap_data;
`ifndef ROM_ARB_FIXED_PRI_EN
  logic last_gnt;
`endif
  always_comb begin
    elig0 = i_req0_valid && (!o_rsp0_valid || i_rsp0_ready);
    elig1 = i_req1_valid && (!o_rsp1_valid || i_rsp1_ready);
`ifdef ROM_ARB_FIXED_PRI_EN
    gnt0 = !i_rst && elig0;
    gnt1 = !i_rst && elig1 && !elig0;
`else
    gnt0 = !i_rst && elig0 && (!elig1 || last_gnt);
    gnt1 = !i_rst && elig1 && (!elig0 || !last_gnt);
`endif
    o_rom_addr = gnt0 ? i_req0_addr : gnt1 ? i_req1_addr : '0;
    oor = {1'b0, o_rom_addr} >= rom_limit;
    cap_data = oor ? '0 : i_rom_data;
  end
  assign o_req0_ready = gnt0;
  assign o_req1_ready = gnt1;
  // a grant refills the slot on the same edge the old response is consumed
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rsp0_valid <= 1'b0;
      o_rsp0_data  <= '0;
      o_rsp0_err   <= 1'b0;
      o_rsp1_valid <= 1'b0;
      o_rsp1_data  <= '0;
      o_rsp1_err   <= 1'b0;
`ifndef ROM_ARB_FIXED_PRI_EN
      last_gnt     <= 1'b1;
`endif
    end else begin
      if (gnt0) begin
        o_rsp0_valid <= 1'b1;
        o_rsp0_data  <= cap_data;
        o_rsp0_err   <= oor;
      end else if (i_rsp0_ready) begin
        o_rsp0_valid <= 1'b0;
      end
      if (gnt1) begin
        o_rsp1_valid <= 1'b1;
        o_rsp1_data  <= cap_data;
        o_rsp1_err   <= oor;
      end else if (i_rsp1_ready) begin
        o_rsp1_valid <= 1'b0;
      end
`ifndef ROM_ARB_FIXED_PRI_EN
      if (gnt0 || gnt1) last_gnt <= gnt1;
`endif
    end
  end
endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: table-driven directed check of rom_arbiter against a bench-side ROM image.
module tb_rom_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic v0 = 1'b0, v1 = 1'b0, r0 = 1'b1, r1 = 1'b1;
  logic [31:0] a0 = '0, a1 = '0;
  logic g0, g1, rv0, rv1, re0, re1;
  logic [31:0] rd0, rd1, rom_addr, rom_data;
  int total = 0;
  int bad = 0;

  rom_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ROM_BLOCK(1024)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(v0), .i_req0_addr(a0), .o_req0_ready(g0),
    .i_req1_valid(v1), .i_req1_addr(a1), .o_req1_ready(g1),
    .o_rsp0_valid(rv0), .o_rsp0_data(rd0), .o_rsp0_err(re0), .i_rsp0_ready(r0),
    .o_rsp1_valid(rv1), .o_rsp1_data(rd1), .o_rsp1_err(re1), .i_rsp1_ready(r1),
    .o_rom_addr(rom_addr), .i_rom_data(rom_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  assign rom_data = rom(rom_addr);

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  typedef struct {
    logic rst, v0; logic [31:0] a0; logic v1; logic [31:0] a1; logic r0, r1;
    logic g0, g1; logic [31:0] ra;
    logic rv0; logic [31:0] rd0; logic re0;
    logic rv1; logic [31:0] rd1; logic re1;
  } vec_t;

  function automatic vec_t mk(
    input logic rst_i, input logic v0_i, input logic [31:0] a0_i, input logic v1_i, input logic [31:0] a1_i,
    input logic r0_i, input logic r1_i, input logic g0_i, input logic g1_i, input logic [31:0] ra_i,
    input logic rv0_i, input logic [31:0] rd0_i, input logic re0_i,
    input logic rv1_i, input logic [31:0] rd1_i, input logic re1_i);
    vec_t t;
    t.rst = rst_i; t.v0 = v0_i; t.a0 = a0_i; t.v1 = v1_i; t.a1 = a1_i; t.r0 = r0_i; t.r1 = r1_i;
    t.g0 = g0_i; t.g1 = g1_i; t.ra = ra_i;
    t.rv0 = rv0_i; t.rd0 = rd0_i; t.re0 = re0_i; t.rv1 = rv1_i; t.rd1 = rd1_i; t.re1 = re1_i;
    return t;
  endfunction

  vec_t tbl[18];

  initial begin
    @(negedge clk);
`ifdef ROM_ARB_FIXED_PRI_EN
    rst = 1'b0; v0 = 1'b1; a0 = 32'd5; v1 = 1'b1; a1 = 32'd9; r0 = 1'b1; r1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("fix_g0", k, 32'(g0), 32'd1);
      check("fix_g1", k, 32'(g1), 32'd0);
      check("fix_addr", k, rom_addr, 32'd5);
      @(negedge clk);
    end
    #1;
    check("fix_rsp0", 0, rd0, rom(32'd5));
    check("fix_rv1", 0, 32'(rv1), 32'd0);
`else
    //            rst v0 a0    v1 a1    r0 r1 g0 g1 raddr  rv0 rd0          re0 rv1 rd1           re1
    tbl[0]  = mk(1, 1, 5,    1, 9,    1, 1, 0, 0, 0,     0, 0,           0,  0, 0,            0);
    tbl[1]  = mk(0, 1, 5,    1, 9,    1, 1, 1, 0, 5,     0, 0,           0,  0, 0,            0);
    tbl[2]  = mk(0, 1, 5,    1, 9,    1, 1, 0, 1, 9,     1, rom(5),      0,  0, 0,            0);
    tbl[3]  = mk(0, 1, 5,    1, 9,    1, 1, 1, 0, 5,     0, rom(5),      0,  1, rom(9),       0);
    tbl[4]  = mk(0, 0, 0,    1, 1024, 1, 1, 0, 1, 1024,  1, rom(5),      0,  0, rom(9),       0);
    tbl[5]  = mk(0, 0, 0,    1, 1023, 1, 1, 0, 1, 1023,  0, rom(5),      0,  1, 0,            1);
    tbl[6]  = mk(0, 1, 7,    0, 0,    1, 0, 1, 0, 7,     0, rom(5),      0,  1, rom(1023),    0);
    tbl[7]  = mk(0, 1, 3,    1, 2,    0, 1, 0, 1, 2,     1, rom(7),      0,  1, rom(1023),    0);
    tbl[8]  = mk(0, 1, 3,    1, 4,    0, 1, 0, 1, 4,     1, rom(7),      0,  1, rom(2),       0);
    tbl[9]  = mk(0, 1, 3,    1, 6,    0, 1, 0, 1, 6,     1, rom(7),      0,  1, rom(4),       0);
    tbl[10] = mk(0, 1, 3,    1, 8,    0, 1, 0, 1, 8,     1, rom(7),      0,  1, rom(6),       0);
    tbl[11] = mk(0, 1, 3,    0, 0,    1, 1, 1, 0, 3,     1, rom(7),      0,  1, rom(8),       0);
    tbl[12] = mk(1, 1, 5,    1, 9,    0, 0, 0, 0, 0,     1, rom(3),      0,  0, rom(8),       0);
    tbl[13] = mk(0, 1, 5,    1, 9,    1, 1, 1, 0, 5,     0, 0,           0,  0, 0,            0);
    tbl[14] = mk(0, 0, 0,    0, 0,    1, 1, 0, 0, 0,     1, rom(5),      0,  0, 0,            0);
    tbl[15] = mk(0, 0, 0,    0, 0,    1, 1, 0, 0, 0,     0, rom(5),      0,  0, 0,            0);
    tbl[16] = mk(0, 1, 10,   1, 11,   1, 1, 0, 1, 11,    0, rom(5),      0,  0, 0,            0);
    tbl[17] = mk(0, 0, 0,    0, 0,    1, 1, 0, 0, 0,     0, rom(5),      0,  1, rom(11),      0);
    for (int i = 0; i < 18; i++) begin
      rst = tbl[i].rst; v0 = tbl[i].v0; a0 = tbl[i].a0; v1 = tbl[i].v1; a1 = tbl[i].a1;
      r0 = tbl[i].r0; r1 = tbl[i].r1;
      #1;
      check("ready0", i, 32'(g0), 32'(tbl[i].g0));
      check("ready1", i, 32'(g1), 32'(tbl[i].g1));
      check("rom_addr", i, rom_addr, tbl[i].ra);
      check("rsp0_valid", i, 32'(rv0), 32'(tbl[i].rv0));
      if (tbl[i].rv0 || tbl[i].rst) check("rsp0_data", i, rd0, tbl[i].rd0);
      check("rsp0_err", i, 32'(re0), 32'(tbl[i].re0));
      check("rsp1_valid", i, 32'(rv1), 32'(tbl[i].rv1));
      if (tbl[i].rv1 || tbl[i].rst) check("rsp1_data", i, rd1, tbl[i].rd1);
      check("rsp1_err", i, 32'(re1), 32'(tbl[i].re1));
      @(negedge clk);
    end
    // held response under backpressure, then same-cycle regrant on release
    v0 = 1'b1; a0 = 32'd20; v1 = 1'b0; r0 = 1'b0; r1 = 1'b1;
    #1;
    check("hold_grant", 0, 32'(g0), 32'd1);
    @(negedge clk);
    a0 = 32'd21;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("hold_ready0", k, 32'(g0), 32'd0);
      check("hold_valid0", k, 32'(rv0), 32'd1);
      check("hold_data0", k, rd0, rom(32'd20));
      @(negedge clk);
    end
    r0 = 1'b1;
    #1;
    check("release_ready0", 0, 32'(g0), 32'd1);
    check("release_addr", 0, rom_addr, 32'd21);
    @(negedge clk);
    v0 = 1'b0;
    #1;
    check("release_data0", 0, rd0, rom(32'd21));
    check("release_valid0", 0, 32'(rv0), 32'd1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
